// File: rtl/core_pkg.sv
// core_pkg: op encodings, FSM states and default widths shared by the execute stage.
package core_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;

  typedef enum logic [3:0] {
    OP_LD   = 4'd0,
    OP_SD   = 4'd1,
    OP_BEQ  = 4'd2,
    OP_BNE  = 4'd3,
    OP_ADDI = 4'd4,
    OP_XORI = 4'd5,
    OP_ORI  = 4'd6,
    OP_ANDI = 4'd7,
    OP_SLLI = 4'd8,
    OP_SRLI = 4'd9,
    OP_ADD  = 4'd10,
    OP_SUB  = 4'd11,
    OP_XOR  = 4'd12,
    OP_OR   = 4'd13,
    OP_AND  = 4'd14,
    OP_NOP  = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  // ALU ops are the contiguous block ADDI..AND; only these ever write a register directly
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADDI) && (op <= OP_AND);
  endfunction

endpackage

// File: rtl/ex_alu.sv
// ex_alu: combinational result and branch-compare for the execute stage.
module ex_alu
  import core_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_rs1,
  input  logic [DATA_W-1:0] i_rs2,
  input  logic [DATA_W-1:0] i_imm,
  output logic [DATA_W-1:0] o_result,
  output logic              o_br_taken
);

  logic [5:0] w_shamt;
  logic       w_equal;

  assign w_shamt = i_imm[5:0];
  assign w_equal = (i_rs1 == i_rs2);

  // result mux; loads and stores reuse the rs1+imm adder for the address
  always_comb begin
    o_result = '0;
    case (i_op)
      OP_LD, OP_SD, OP_ADDI: o_result = i_rs1 + i_imm;
      OP_XORI:               o_result = i_rs1 ^ i_imm;
      OP_ORI:                o_result = i_rs1 | i_imm;
      OP_ANDI:               o_result = i_rs1 & i_imm;
      OP_SLLI:               o_result = i_rs1 << w_shamt;
      OP_SRLI:               o_result = i_rs1 >> w_shamt;
      OP_ADD:                o_result = i_rs1 + i_rs2;
      OP_SUB:                o_result = i_rs1 - i_rs2;
      OP_XOR:                o_result = i_rs1 ^ i_rs2;
      OP_OR:                 o_result = i_rs1 | i_rs2;
      OP_AND:                o_result = i_rs1 & i_rs2;
      default:               o_result = '0;
    endcase
  end

  assign o_br_taken = (i_op == OP_BNE) ? !w_equal : w_equal;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute/memory stage with load/store handshake and registered write-back.
module ex_stage
  import core_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_rs1,
  input  logic [DATA_W-1:0] i_rs2,
  input  logic [4:0]        i_rd_id,
  input  logic [DATA_W-1:0] i_imm,
  input  logic              i_finish,
  output logic              o_d_valid_addr,
  output logic              o_d_we,
  output logic [ADDR_W-1:0] o_d_addr,
  output logic [DATA_W-1:0] o_d_wdata,
  input  logic              i_d_valid_data,
  input  logic [DATA_W-1:0] i_d_data,
  output logic              o_wb_valid,
  output logic [4:0]        o_wb_rd_id,
  output logic [DATA_W-1:0] o_wb_data,
  output logic              o_br_valid,
  output logic              o_br_taken,
  output logic [ADDR_W-1:0] o_br_offset,
  output logic              o_done,
  output logic              o_busy,
  output logic              o_finish
);

  state_e            r_state;
  state_e            w_next_state;
  logic              w_accept;
  logic              w_ld_return;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_br_taken;
  logic [DATA_W-1:0] w_imm_x2;

  logic              r_d_valid_addr;
  logic              r_d_we;
  logic [ADDR_W-1:0] r_d_addr;
  logic [DATA_W-1:0] r_d_wdata;
  logic              r_wb_valid;
  logic [4:0]        r_wb_rd_id;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_br_valid;
  logic              r_br_taken;
  logic [ADDR_W-1:0] r_br_offset;
  logic              r_done;
  logic              r_finish;
  logic [4:0]        r_ld_rd;

  ex_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op       (i_op),
    .i_rs1      (i_rs1),
    .i_rs2      (i_rs2),
    .i_imm      (i_imm),
    .o_result   (w_alu_result),
    .o_br_taken (w_br_taken)
  );

  assign w_accept    = i_valid && (r_state == IDLE) && !r_finish;
  assign w_ld_return = (r_state == MEM_WAIT) && i_d_valid_data;
  assign w_imm_x2    = {i_imm[DATA_W-2:0], 1'b0};

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // next state: only loads leave IDLE; stores, branches and ALU ops retire in one cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (w_accept && (i_op == OP_LD)) w_next_state = MEM_REQ;
      MEM_REQ:  w_next_state = MEM_WAIT;
      MEM_WAIT: if (i_d_valid_data) w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // output registers: strobes fall back to 0 each cycle, data fields hold until rewritten
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_d_valid_addr <= 1'b0;
      r_d_we         <= 1'b0;
      r_d_addr       <= '0;
      r_d_wdata      <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_rd_id     <= '0;
      r_wb_data      <= '0;
      r_br_valid     <= 1'b0;
      r_br_taken     <= 1'b0;
      r_br_offset    <= '0;
      r_done         <= 1'b0;
      r_finish       <= 1'b0;
      r_ld_rd        <= '0;
    end else begin
      r_d_valid_addr <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_br_valid     <= 1'b0;
      r_done         <= 1'b0;
      if (w_accept) begin
        r_done <= 1'b1;
        case (i_op)
          OP_LD: begin
            r_done         <= 1'b0;
            r_d_valid_addr <= 1'b1;
            r_d_we         <= 1'b0;
            r_d_addr       <= ADDR_W'(w_alu_result);
            r_ld_rd        <= i_rd_id;
          end
          OP_SD: begin
            r_d_valid_addr <= 1'b1;
            r_d_we         <= 1'b1;
            r_d_addr       <= ADDR_W'(w_alu_result);
            r_d_wdata      <= i_rs2;
          end
          OP_BEQ, OP_BNE: begin
            r_br_valid  <= 1'b1;
            r_br_taken  <= w_br_taken;
            r_br_offset <= ADDR_W'(w_imm_x2);
          end
          default: begin
            if (is_alu_op(i_op) && (i_rd_id != 5'd0)) begin
              r_wb_valid <= 1'b1;
              r_wb_rd_id <= i_rd_id;
              r_wb_data  <= w_alu_result;
            end
          end
        endcase
      end
      if (w_ld_return) begin
        r_done <= 1'b1;
        if (r_ld_rd != 5'd0) begin
          r_wb_valid <= 1'b1;
          r_wb_rd_id <= r_ld_rd;
          r_wb_data  <= i_d_data;
        end
      end
      if (i_finish && !i_valid) r_finish <= 1'b1;
    end
  end

  assign o_d_valid_addr = r_d_valid_addr;
  assign o_d_we         = r_d_we;
  assign o_d_addr       = r_d_addr;
  assign o_d_wdata      = r_d_wdata;
  assign o_wb_valid     = r_wb_valid;
  assign o_wb_rd_id     = r_wb_rd_id;
  assign o_wb_data      = r_wb_data;
  assign o_br_valid     = r_br_valid;
  assign o_br_taken     = r_br_taken;
  assign o_br_offset    = r_br_offset;
  assign o_done         = r_done;
  assign o_busy         = (r_state != IDLE);
  assign o_finish       = r_finish;

endmodule
